// File: rtl/alu_issue_seq_if.sv
// Bundle between alu_issue_seq and its surroundings: the instruction
// handshake, the ALU operand/result/flag wires, completion status and the
// register-file debug read port.
interface alu_issue_seq_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int OPW   = 4
);
    localparam int AW = $clog2(NREGS);

    // Instruction channel
    logic             instr_valid;
    logic             instr_ready;
    logic [OPW-1:0]   instr_op;
    logic [AW-1:0]    instr_rd;
    logic [AW-1:0]    instr_ra;
    logic [AW-1:0]    instr_rb;
    logic             instr_imm_en;
    logic [WIDTH-1:0] instr_imm;

    // ALU connection
    logic [WIDTH-1:0] alu_ina;
    logic [WIDTH-1:0] alu_inb;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_bigger;

    // Completion status and debug
    logic             done;
    logic             flag_c;
    logic             flag_z;
    logic             flag_b;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    // Sequencer side
    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
               instr_imm_en, instr_imm,
               alu_out, alu_carry, alu_zero, alu_bigger,
               dbg_addr,
        output instr_ready, alu_ina, alu_inb, alu_op,
               done, flag_c, flag_z, flag_b, dbg_data
    );

    // Instruction source / ALU / debug side
    modport master (
        output instr_valid, instr_op, instr_rd, instr_ra, instr_rb,
               instr_imm_en, instr_imm,
               alu_out, alu_carry, alu_zero, alu_bigger,
               dbg_addr,
        input  instr_ready, alu_ina, alu_inb, alu_op,
               done, flag_c, flag_z, flag_b, dbg_data
    );
endinterface

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer for a 16-bit ALU. Accepts one instruction per
// handshake, presents register-file (or immediate) operands to the ALU,
// captures the result, writes it back and latches the ALU flags.
// Sequence per instruction: IDLE (accept) -> ISSUE -> WB -> IDLE.
module alu_issue_seq #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int OPW   = 4
) (
    input logic           clk,
    input logic           rst,
    alu_issue_seq_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] ra_val;
    logic [WIDTH-1:0] rb_val;

    logic [WIDTH-1:0] ina_q;
    logic [WIDTH-1:0] inb_q;
    logic [OPW-1:0]   op_q;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] result_q;
    logic             flag_c_q;
    logic             flag_z_q;
    logic             flag_b_q;

    logic             instr_ready;
    logic             done;
    logic             accept;

    // Register 0 is hard-wired to zero on every read port.
    assign ra_val = (bus.instr_ra == '0) ? '0 : regs[bus.instr_ra];
    assign rb_val = (bus.instr_rb == '0) ? '0 : regs[bus.instr_rb];
    assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : regs[bus.dbg_addr];

    // State register; reset has priority over any handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake/status decode; rst masks both so an instruction
    // offered during reset is never accepted and an interrupted WB never
    // reports completion.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = ~rst;
                if (bus.instr_valid && !rst) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WB;
            WB: begin
                done      = ~rst;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept          = bus.instr_valid & instr_ready;
    assign bus.instr_ready = instr_ready;
    assign bus.done        = done;

    // Operand/opcode latches (held until the next accept), result capture at
    // the end of ISSUE, flag capture at the end of WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            ina_q    <= '0;
            inb_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_b_q <= 1'b0;
        end else begin
            if (accept) begin
                ina_q <= ra_val;
                inb_q <= bus.instr_imm_en ? bus.instr_imm : rb_val;
                op_q  <= bus.instr_op;
                rd_q  <= bus.instr_rd;
            end
            if (state == ISSUE) result_q <= bus.alu_out;
            if (state == WB) begin
                flag_c_q <= bus.alu_carry;
                flag_z_q <= bus.alu_zero;
                flag_b_q <= bus.alu_bigger;
            end
        end
    end

    // Register file write-back; writes to register 0 are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this small register file is cleared on reset because the
            // architecture defines all registers as zero afterwards; a large
            // RAM would normally be left unreset.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (state == WB && rd_q != '0) begin
            regs[rd_q] <= result_q;
        end
    end

    assign bus.alu_ina = ina_q;
    assign bus.alu_inb = inb_q;
    assign bus.alu_op  = op_q;
    assign bus.flag_c  = flag_c_q;
    assign bus.flag_z  = flag_z_q;
    assign bus.flag_b  = flag_b_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: includes a stand-in ALU (combinational out,
// flags registered on clk), a reference register-file model and a scoreboard
// of expected write-backs popped when the sequencer reports done.
module tb_alu_issue_seq;
    logic clk;
    logic rst;

    alu_issue_seq_if #(.WIDTH(16), .NREGS(8), .OPW(4)) bus ();

    alu_issue_seq #(.WIDTH(16), .NREGS(8), .OPW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        b;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mr [8];
    int          n_checks = 0;
    int          n_pass   = 0;

    // ALU behaviour: 0 pass B, 1 add, 2 sub (carry = borrow), 3 and, 4 or, 5 xor.
    function automatic void alu_ref(input logic [3:0] op, input logic [15:0] a, b,
                                    output logic [15:0] r, output logic c, z, bg);
        logic [16:0] s;
        c = 1'b0;
        case (op)
            4'd0: r = b;
            4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
            4'd2: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16]; end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            default: r = a;
        endcase
        z  = (r == 16'h0000);
        bg = (a > b);
    endfunction

    // Stand-in ALU
    logic [15:0] alu_r;
    logic        alu_c_n, alu_z_n, alu_b_n;
    always_comb alu_ref(bus.alu_op, bus.alu_ina, bus.alu_inb, alu_r, alu_c_n, alu_z_n, alu_b_n);
    assign bus.alu_out = alu_r;
    initial begin
        bus.alu_carry  = 1'b0;
        bus.alu_zero   = 1'b0;
        bus.alu_bigger = 1'b0;
    end
    always @(posedge clk) begin
        bus.alu_carry  <= alu_c_n;
        bus.alu_zero   <= alu_z_n;
        bus.alu_bigger <= alu_b_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mr[i] = 16'h0000;
        sb.delete();
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] rd, ra, rb,
                         input logic imm_en, input logic [15:0] imm);
        bus.instr_op     = op;
        bus.instr_rd     = rd;
        bus.instr_ra     = ra;
        bus.instr_rb     = rb;
        bus.instr_imm_en = imm_en;
        bus.instr_imm    = imm;
    endtask

    // Compute and enqueue the expected write-back, updating the model regfile.
    task automatic expect_instr(input logic [3:0] op, input logic [2:0] rd, ra, rb,
                                input logic imm_en, input logic [15:0] imm,
                                output logic [15:0] a, output logic [15:0] b);
        exp_t e;
        a = mr[ra];
        b = imm_en ? imm : mr[rb];
        alu_ref(op, a, b, e.res, e.c, e.z, e.b);
        e.rd = rd;
        sb.push_back(e);
        if (rd != 3'd0) mr[rd] = e.res;
    endtask

    task automatic check_wb(input string tag, input exp_t e);
        check({tag, "_flag_c"}, bus.flag_c, e.c);
        check({tag, "_flag_z"}, bus.flag_z, e.z);
        check({tag, "_flag_b"}, bus.flag_b, e.b);
        bus.dbg_addr = e.rd;
        #1;
        check({tag, "_rd"}, bus.dbg_data, mr[e.rd]);
    endtask

    // One instruction: accept, ISSUE operands, done in cycle 2 after the
    // accept cycle, single-cycle pulse, then flags and write-back.
    task automatic issue(input string tag, input logic [3:0] op, input logic [2:0] rd, ra, rb,
                         input logic imm_en, input logic [15:0] imm);
        logic [15:0] a, b;
        exp_t e;
        int n;
        expect_instr(op, rd, ra, rb, imm_en, imm, a, b);
        @(negedge clk);
        drive(op, rd, ra, rb, imm_en, imm);
        bus.instr_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_accept"}, bus.instr_ready, 1'b1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        #1;
        check({tag, "_ina"}, bus.alu_ina, a);
        check({tag, "_inb"}, bus.alu_inb, b);
        check({tag, "_op"}, bus.alu_op, op);
        check({tag, "_issue_done"}, bus.done, 1'b0);
        check({tag, "_issue_ready"}, bus.instr_ready, 1'b0);
        @(negedge clk); #1;
        check({tag, "_done"}, bus.done, 1'b1);
        check({tag, "_wb_ready"}, bus.instr_ready, 1'b0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1'b1, 1'b0);
            return;
        end
        e = sb.pop_front();
        @(negedge clk); #1;
        check({tag, "_done_pulse"}, bus.done, 1'b0);
        check_wb(tag, e);
    endtask

    initial begin
        exp_t        e;
        logic [15:0] a, b;
        e = '{rd: 3'd0, res: 16'h0, c: 1'b0, z: 1'b0, b: 1'b0};
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.dbg_addr    = 3'd0;
        drive(4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
        model_reset();

        // 1. Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", bus.instr_ready, 1'b1);
        check("rst_done", bus.done, 1'b0);
        check("rst_flags", {bus.flag_c, bus.flag_z, bus.flag_b}, 3'b000);
        check("rst_ina", bus.alu_ina, 16'h0000);
        check("rst_inb", bus.alu_inb, 16'h0000);
        check("rst_op", bus.alu_op, 4'h0);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            check($sformatf("rst_r%0d", i), bus.dbg_data, 16'h0000);
        end

        // 2. R1 = 5 by immediate pass
        issue("ld_r1", 4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005);

        // 3. R2 = 0xFFFF, then R3 = R2 + 1 (wraps, carry, zero, bigger)
        issue("ld_r2", 4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFF);
        issue("add_r3", 4'd1, 3'd3, 3'd2, 3'd0, 1'b1, 16'h0001);

        // 4. R4 = R1 - R1 with valid held high: accepted every 3 cycles
        expect_instr(4'd2, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0000, a, b);
        expect_instr(4'd2, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0000, a, b);
        @(negedge clk);
        drive(4'd2, 3'd4, 3'd1, 3'd1, 1'b0, 16'h0000);
        bus.instr_valid = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("b2b_ready_c%0d", i), bus.instr_ready, (i % 3) == 0);
            check($sformatf("b2b_done_c%0d", i), bus.done, (i % 3) == 2);
            if (i % 3 == 2 && sb.size() != 0) e = sb.pop_front();
            if (i == 3 || i == 6) begin
                check($sformatf("b2b_flags_c%0d", i), {bus.flag_c, bus.flag_z, bus.flag_b},
                      {e.c, e.z, e.b});
            end
            if (i == 6) bus.instr_valid = 1'b0;
            else begin
                @(negedge clk); #1;
            end
        end
        bus.dbg_addr = 3'd4;
        #1;
        check("b2b_r4", bus.dbg_data, mr[4]);
        check("b2b_sb_drained", sb.size(), 0);

        // 5. Write to R0 is discarded
        issue("wr_r0", 4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234);

        // Set all flags so the reset below has something to clear
        issue("add_r6", 4'd1, 3'd6, 3'd2, 3'd0, 1'b1, 16'h0001);

        // 6. Reset during ISSUE drops the instruction
        @(negedge clk);
        drive(4'd1, 3'd5, 3'd1, 3'd0, 1'b1, 16'h0003);
        bus.instr_valid = 1'b1;
        #1;
        check("rsti_accept", bus.instr_ready, 1'b1);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rsti_issue_done", bus.done, 1'b0);
        check("rsti_issue_ready", bus.instr_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("rsti_idle_done", bus.done, 1'b0);
        check("rsti_idle_ready", bus.instr_ready, 1'b1);
        @(negedge clk); #1;
        check("rsti_no_done", bus.done, 1'b0);
        check("rsti_flags", {bus.flag_c, bus.flag_z, bus.flag_b}, 3'b000);
        check("rsti_ina", bus.alu_ina, 16'h0000);
        for (int i = 1; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            check($sformatf("rsti_r%0d", i), bus.dbg_data, mr[i]);
        end

        // Sequencer still works after the interrupted instruction
        issue("post_rst", 4'd5, 3'd7, 3'd0, 3'd0, 1'b1, 16'hA5A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
